// File: rtl/cn_pkg.sv
// Shared types and constants for the check-node message generator.
package cn_pkg;

  localparam int unsigned N_VAR  = 10;
  localparam int unsigned MAG_W  = 7;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OFFSET = 1;

  typedef logic [MAG_W-1:0] cn_mag_t;
  typedef logic [IDX_W-1:0] cn_idx_t;
  typedef logic [N_VAR-1:0] cn_sign_t;

  typedef struct packed {
    logic    sign;
    cn_mag_t mag;
    cn_idx_t idx;
  } cn_msg_t;

  // FSM encoding
  localparam logic [0:0] CN_IDLE = 1'b0;
  localparam logic [0:0] CN_EMIT = 1'b1;

  localparam cn_idx_t CN_LAST_IDX = IDX_W'(N_VAR - 1);

endpackage

// File: rtl/cn_offset_sat.sv
// Offset min-sum magnitude correction: subtract OFFSET with a floor at zero.
module cn_offset_sat
  import cn_pkg::*;
(
  input  logic [MAG_W-1:0] raw,
  output logic [MAG_W-1:0] mag_c
);

  // Compare first so small magnitudes clamp to zero instead of wrapping.
  assign mag_c = (raw >= MAG_W'(OFFSET)) ? (raw - MAG_W'(OFFSET)) : '0;

endmodule

// File: rtl/cn_msg_gen.sv
// Check-node message generator: expands one two-min summary into N_VAR messages.
// Optional macro CN_OVERLAP_EN enables zero-bubble back-to-back summaries.
module cn_msg_gen
  import cn_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [MAG_W-1:0]  i_min0,
  input  logic [MAG_W-1:0]  i_min1,
  input  logic [IDX_W-1:0]  i_min0_idx,
  input  logic [N_VAR-1:0]  i_sign,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_msg_sign,
  output logic [MAG_W-1:0]  o_msg_mag,
  output logic [IDX_W-1:0]  o_msg_idx,
  output logic              o_last
);

  logic [0:0] state_q, state_d;
  cn_idx_t    cnt_q, cnt_d;
  cn_mag_t    min0_q, min0_d;
  cn_mag_t    min1_q, min1_d;
  cn_idx_t    midx_q, midx_d;
  cn_sign_t   sign_q, sign_d;
  logic       parity_q, parity_d;
  cn_msg_t    msg_q, msg_d;
  logic       last_q, last_d;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;

  logic       accept_c;
  logic       fire_c;
  logic       at_last_c;

  // Source mux for the next message: fresh summary on load, captured one otherwise
  cn_idx_t    calc_k;
  cn_mag_t    src_min0;
  cn_mag_t    src_min1;
  cn_idx_t    src_idx;
  cn_sign_t   src_sign;
  logic       src_parity;
  cn_mag_t    calc_raw;
  cn_mag_t    calc_mag;
  logic       calc_sign;

  assign at_last_c = (state_q == CN_EMIT) && (cnt_q == CN_LAST_IDX);
  assign fire_c    = valid_q && i_ready;

`ifdef CN_OVERLAP_EN
  assign o_ready   = ready_q || (at_last_c && i_ready);
`else
  assign o_ready   = ready_q;
`endif

  assign accept_c  = i_valid && o_ready;

  always_comb begin
    calc_k     = accept_c ? '0         : cnt_q + IDX_W'(1);
    src_min0   = accept_c ? i_min0     : min0_q;
    src_min1   = accept_c ? i_min1     : min1_q;
    src_idx    = accept_c ? i_min0_idx : midx_q;
    src_sign   = accept_c ? i_sign     : sign_q;
    src_parity = accept_c ? ^i_sign    : parity_q;
    // An out-of-range min0 index never matches k, so every edge gets min0.
    calc_raw   = (calc_k == src_idx) ? src_min1 : src_min0;
  end

  cn_offset_sat u_offset_sat (
    .raw   (calc_raw),
    .mag_c (calc_mag)
  );

  // Suppress negative zero.
  assign calc_sign = (src_parity ^ src_sign[calc_k]) && (calc_mag != '0);

  // Next-state and output-register logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    min0_d   = min0_q;
    min1_d   = min1_q;
    midx_d   = midx_q;
    sign_d   = sign_q;
    parity_d = parity_q;
    msg_d    = msg_q;
    last_d   = last_q;
    valid_d  = valid_q;
    ready_d  = ready_q;

    if (accept_c) begin
      min0_d   = i_min0;
      min1_d   = i_min1;
      midx_d   = i_min0_idx;
      sign_d   = i_sign;
      parity_d = ^i_sign;
    end

    case (state_q)
      CN_IDLE: begin
        if (accept_c) begin
          state_d    = CN_EMIT;
          cnt_d      = '0;
          msg_d.sign = calc_sign;
          msg_d.mag  = calc_mag;
          msg_d.idx  = calc_k;
          last_d     = (calc_k == CN_LAST_IDX);
          valid_d    = 1'b1;
          ready_d    = 1'b0;
        end
      end
      CN_EMIT: begin
        if (fire_c) begin
          if (at_last_c && !accept_c) begin
            state_d = CN_IDLE;
            cnt_d   = '0;
            msg_d   = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end else begin
            cnt_d      = calc_k;
            msg_d.sign = calc_sign;
            msg_d.mag  = calc_mag;
            msg_d.idx  = calc_k;
            last_d     = (calc_k == CN_LAST_IDX);
          end
        end
      end
      default: begin
        state_d = CN_IDLE;
        cnt_d   = '0;
        msg_d   = '0;
        last_d  = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= CN_IDLE;
      cnt_q    <= '0;
      min0_q   <= '0;
      min1_q   <= '0;
      midx_q   <= '0;
      sign_q   <= '0;
      parity_q <= 1'b0;
      msg_q    <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min0_q   <= min0_d;
      min1_q   <= min1_d;
      midx_q   <= midx_d;
      sign_q   <= sign_d;
      parity_q <= parity_d;
      msg_q    <= msg_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_msg_sign = msg_q.sign;
  assign o_msg_mag  = msg_q.mag;
  assign o_msg_idx  = msg_q.idx;
  assign o_last     = last_q;

endmodule

// File: tb/tb_cn_msg_gen.sv
// Directed bench for cn_msg_gen; honours CN_OVERLAP_EN when defined.
module tb_cn_msg_gen;

`ifdef CN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [6:0] i_min0 = '0;
  logic [6:0] i_min1 = '0;
  logic [3:0] i_min0_idx = '0;
  logic [9:0] i_sign = '0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic       o_msg_sign;
  logic [6:0] o_msg_mag;
  logic [3:0] o_msg_idx;
  logic       o_last;

  int n_cmp = 0;
  int n_err = 0;

  // {o_ready, o_valid, o_last, o_msg_sign, o_msg_mag, o_msg_idx}
  logic [14:0] got;
  logic [14:0] exp;

  always #5 clk = ~clk;

  cn_msg_gen dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_min0     (i_min0),
    .i_min1     (i_min1),
    .i_min0_idx (i_min0_idx),
    .i_sign     (i_sign),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_msg_sign (o_msg_sign),
    .o_msg_mag  (o_msg_mag),
    .o_msg_idx  (o_msg_idx),
    .o_last     (o_last)
  );

  assign got = {o_ready, o_valid, o_last, o_msg_sign, o_msg_mag, o_msg_idx};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] m0, input logic [6:0] m1,
                       input logic [3:0] idx, input logic [9:0] sg);
    i_valid    = 1'b1;
    i_min0     = m0;
    i_min1     = m1;
    i_min0_idx = idx;
    i_sign     = sg;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    step();
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_idle got %h want %h", got, exp);
    end
  endtask

  task automatic test_basic();
    offer(7'd5, 7'd9, 4'd3, 10'b0);
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {OVL && (k == 9), 1'b1, k == 9, 1'b0, (k == 3) ? 7'd8 : 7'd4, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL basic_k%0d got %h want %h", k, got, exp);
      end
      step();
    end
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL basic_idle got %h want %h", got, exp);
    end
  endtask

  task automatic test_signs();
    offer(7'd3, 7'd3, 4'd0, 10'b0000000101);
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {OVL && (k == 9), 1'b1, k == 9, (k == 0) || (k == 2), 7'd2, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL signs_k%0d got %h want %h", k, got, exp);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    offer(7'd0, 7'd1, 4'd7, 10'b1);
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {OVL && (k == 9), 1'b1, k == 9, 1'b0, 7'd0, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL sat_k%0d got %h want %h", k, got, exp);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    // parity 1, edge 4 negative -> edge 4 positive, others negative
    offer(7'd5, 7'd9, 4'd3, 10'b0000010000);
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {OVL && (k == 9), 1'b1, k == 9, k != 4, (k == 3) ? 7'd8 : 7'd4, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL bp_k%0d got %h want %h", k, got, exp);
      end
      if (k == 4) begin
        i_ready = 1'b0;
        offer(7'd1, 7'd2, 4'd0, 10'h3ff);
        for (int s = 0; s < 3; s++) begin
          step();
          n_cmp++;
          if (got !== exp) begin
            n_err++;
            $display("FAIL bp_stall%0d got %h want %h", s, got, exp);
          end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
      end
      step();
    end
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL bp_idle got %h want %h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    offer(7'd5, 7'd9, 4'd3, 10'b1);
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      exp = {1'b0, 1'b1, 1'b0, k != 0, (k == 3) ? 7'd8 : 7'd4, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rmid_k%0d got %h want %h", k, got, exp);
      end
      if (k < 6) step();
    end
    rst_n = 1'b0;
    #1;
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL rmid_async got %h want %h", got, exp);
    end
    step();
    rst_n = 1'b1;
    step();
    offer(7'd2, 7'd6, 4'd9, 10'b0);
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {OVL && (k == 9), 1'b1, k == 9, 1'b0, (k == 9) ? 7'd5 : 7'd1, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rmid_new_k%0d got %h want %h", k, got, exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    offer(7'd4, 7'd10, 4'd1, 10'b0);
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {OVL && (k == 9), 1'b1, k == 9, 1'b0, (k == 1) ? 7'd9 : 7'd3, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_a_k%0d got %h want %h", k, got, exp);
      end
      // Second summary offered while the last message is presented; illegal idx 12
      if (k == 9) offer(7'd8, 7'd8, 4'd12, 10'b1000000000);
      step();
    end
    if (!OVL) begin
      i_valid = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_bubble got %h want %h", got, exp);
      end
      offer(7'd8, 7'd8, 4'd12, 10'b1000000000);
      step();
    end
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = {OVL && (k == 9), 1'b1, k == 9, k != 9, 7'd7, 4'(k)};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL b2b_b_k%0d got %h want %h", k, got, exp);
      end
      step();
    end
    exp = {1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL b2b_idle got %h want %h", got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
